// File: rtl/rmii_tx.sv
// rtl/rmii_tx.sv - RMII transmit MAC: preamble/SFD, LSB-first dibits, FCS and inter-packet gap
// Define RMII_TX_FCS_EN to generate and append the FCS in hardware; otherwise the user supplies it.
module rmii_tx #(
  parameter int IPG_CYCLES = 48,
  parameter int PRE_BYTES  = 7
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       tx_vld,
  output logic       tx_rdy,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_busy,
  output logic       tx_underrun,
  output logic [1:0] eth_txd,
  output logic       eth_tx_en
);
  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, FCS, IPG} state_t;

  localparam logic [15:0] SFD_LAST = 16'(4 * PRE_BYTES + 3);
  localparam logic [15:0] IPG_LAST = 16'(IPG_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [1:0]  dsel;
  logic [7:0]  data_q;
  logic        last_q;
  logic [1:0]  txd_nxt;
  logic        en_nxt;
  logic [1:0]  data_dibit;
  logic        take;
  logic        underrun;

  assign data_dibit = 2'(data_q >> {dsel, 1'b0});
  assign take       = tx_rdy & tx_vld;
  assign underrun   = tx_rdy & ~tx_vld;

`ifdef RMII_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] fcs_inv;
  logic [1:0]  fcs_dibit;

  // Reflected CRC-32, two bits per step, bit 0 of the dibit first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 2; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  assign fcs_inv   = ~crc;
  assign fcs_dibit = 2'(fcs_inv >> {cnt[3:0], 1'b0});
`endif

  // Outputs are registered from the state cycle, so the wire lags the state by one clk.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tx_rdy    = 1'b0;
    txd_nxt   = 2'b00;
    en_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (tx_vld) begin
          state_nxt = PREAMBLE;
          cnt_nxt   = '0;
        end
      end
      PREAMBLE: begin
        en_nxt  = 1'b1;
        txd_nxt = (cnt == SFD_LAST) ? 2'b11 : 2'b01;
        cnt_nxt = cnt + 16'd1;
        if (cnt == SFD_LAST) begin
          tx_rdy    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = tx_vld ? DATA : IPG;
        end
      end
      DATA: begin
        en_nxt  = 1'b1;
        txd_nxt = data_dibit;
        if (dsel == 2'd3) begin
          if (last_q) begin
`ifdef RMII_TX_FCS_EN
            state_nxt = FCS;
`else
            state_nxt = IPG;
`endif
            cnt_nxt = '0;
          end else begin
            tx_rdy = 1'b1;
            if (!tx_vld) begin
              state_nxt = IPG;
              cnt_nxt   = '0;
            end
          end
        end
      end
`ifdef RMII_TX_FCS_EN
      FCS: begin
        en_nxt  = 1'b1;
        txd_nxt = fcs_dibit;
        cnt_nxt = cnt + 16'd1;
        if (cnt == 16'd15) begin
          state_nxt = IPG;
          cnt_nxt   = '0;
        end
      end
`endif
      IPG: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == IPG_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      cnt         <= '0;
      dsel        <= 2'd0;
      data_q      <= 8'h00;
      last_q      <= 1'b0;
      eth_txd     <= 2'b00;
      eth_tx_en   <= 1'b0;
      tx_busy     <= 1'b0;
      tx_underrun <= 1'b0;
`ifdef RMII_TX_FCS_EN
      crc         <= 32'hFFFFFFFF;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      eth_txd     <= txd_nxt;
      eth_tx_en   <= en_nxt;
      tx_busy     <= (state != IDLE);
      tx_underrun <= underrun;
      dsel        <= (state == DATA && state_nxt == DATA) ? dsel + 2'd1 : 2'd0;
      if (take) begin
        data_q <= tx_data;
        last_q <= tx_last;
      end
`ifdef RMII_TX_FCS_EN
      if (state == DATA) begin
        crc <= crc_dibit(crc, data_dibit);
      end else if (state == IDLE || state == IPG) begin
        crc <= 32'hFFFFFFFF;
      end
`endif
    end
  end
endmodule
